// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: FSM state codes, word geometry
// and the frame length limit helper.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD  = 4;
    localparam int DEPTH_WORDS_DEF = 64;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    // Largest legal LEN byte for a RAM of the given depth; the LEN
    // field is one byte wide, so deeper RAMs saturate at 255 words.
    function automatic logic [7:0] len_max(input int depth);
        int d;
        d = (depth > 255) ? 255 : depth;
        return d[7:0];
    endfunction

    localparam logic [7:0] LEN_MAX = len_max(DEPTH_WORDS_DEF);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-lane packer: places incoming bytes little-endian into a
// 32-bit word and flags the byte that completes the word.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    localparam int LW = $clog2(BYTES_PER_WORD);
    localparam logic [LW-1:0] LAST = LW'(BYTES_PER_WORD - 1);

    logic [LW-1:0] lane_q, lane_d;
    logic [31:0]   word_q, word_d;

    // The lane counter wraps naturally after the top lane.
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
        end else if (load_i) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (lane_q == LW'(i)) begin
                    word_d[8*i +: 8] = byte_i;
                end
            end
            lane_d = lane_q + LW'(1);
        end
    end

    // Lane counter and packed word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = load_i && (lane_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM loader: receives a LEN/data/XOR-checksum frame,
// writes words to the RAM and holds the core until a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [31:0]           wData,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDXW = $clog2(DEPTH_WORDS + 1);
    localparam logic [7:0] LMAX = len_max(DEPTH_WORDS);

    logic [2:0]      state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [7:0]      csum_q, csum_d;
    logic [IDXW-1:0] word_idx_q, word_idx_d;

    logic       xfer;
    logic       asm_clear;
    logic       asm_load;
    logic       asm_full;
    logic [7:0] idx8;

    assign rx_ready = (state_q == S_LEN)
                   || (state_q == S_DATA)
                   || (state_q == S_CHK);
    assign we       = (state_q == S_WRITE);
    assign busy     = rx_ready || we;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_hold = busy || err;

    assign xfer     = rx_valid && rx_ready;
    assign asm_load = (state_q == S_DATA) && xfer;
    assign idx8     = 8'(word_idx_q);

    assign wAddr = ADDR_WIDTH'({word_idx_q, 2'b00});

    imem_loader_word_assembler u_word_assembler (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (asm_clear),
        .load_i      (asm_load),
        .byte_i      (rx_data),
        .word_o      (wData),
        .word_full_o (asm_full)
    );

    // Frame sequencing: length check, word writes, checksum verdict.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        csum_d     = csum_q;
        word_idx_d = word_idx_q;
        asm_clear  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    n_d        = '0;
                    csum_d     = '0;
                    word_idx_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (rx_data == 8'd0 || rx_data > LMAX) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = rx_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                    if (asm_full) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + IDXW'(1);
                if (idx8 == n_q - 8'd1) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, length, checksum and word index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            csum_q     <= '0;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            csum_q     <= csum_d;
            word_idx_q <= word_idx_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level model
// predicts RAM writes and the final verdict.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] wAddr;
    logic [31:0] wData;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .wAddr    (wAddr),
        .wData    (wData),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         checks = 0;
    int         errors = 0;
    bit         exp_done;
    bit         exp_err;
    int         exp_len;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the next predicted write.
    always @(negedge clk) begin
        if (reset_n && we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         wAddr, wData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wAddr", wAddr, e.addr);
                check("wData", wData, e.data);
                check("rx_ready_in_write", 32'(rx_ready), 32'd0);
            end
        end
    end

    // Reference model: parse the frame by its rules, queue writes.
    task automatic model_frame();
        int         n;
        logic [7:0] cs;
        logic [31:0] word;
        wr_t        e;
        n  = int'(frame[0]);
        cs = 8'h00;
        if (n == 0 || n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_len  = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            word = 32'h0;
            for (int b = 0; b < 4; b++) begin
                word = word | (32'(frame[1 + 4*w + b]) << (8*b));
                cs   = cs ^ frame[1 + 4*w + b];
            end
            e.addr = 32'(w * 4);
            e.data = word;
            exp_q.push_back(e);
        end
        exp_len  = 4*n + 2;
        exp_done = (frame[4*n + 1] == cs);
        exp_err  = !exp_done;
    endtask

    task automatic make_frame(input int n, input bit good);
        logic [7:0] cs;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        if (n == 0 || n > DEPTH) return;
        cs = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b  = 8'($urandom);
            cs = cs ^ b;
            frame.push_back(b);
        end
        if (!good) cs = cs ^ 8'($urandom_range(1, 255));
        frame.push_back(cs);
    endtask

    task automatic nominal_frame(input logic [7:0] chk);
        frame = '{8'h02, 8'h13, 8'h05, 8'h50, 8'h00,
                  8'h93, 8'h05, 8'h75, 8'h00};
        frame.push_back(chk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got rx_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse_start(input bit with_valid);
        @(negedge clk);
        start = 1'b1;
        if (with_valid) begin
            rx_valid = 1'b1;
            rx_data  = frame[0];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int gmin, input int gmax,
                             input bit mid_start, input bit with_valid);
        model_frame();
        pulse_start(with_valid);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(err), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < exp_len; i++) begin
            if (mid_start && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(frame[i], (with_valid && i == 0) ? 0
                                : $urandom_range(gmin, gmax));
        end
        check("end_done", 32'(done), 32'(exp_done));
        check("end_err", 32'(err), 32'(exp_err));
        check("end_cpu_hold", 32'(cpu_hold), 32'(exp_err));
        check("end_busy", 32'(busy), 32'd0);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("level_done", 32'(done), 32'(exp_done));
        check("level_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wAddr", wAddr, 32'd0);
        check("rst_wData", wData, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        nominal_frame(8'hA5);
        run_frame(0, 0, 1'b0, 1'b0);

        nominal_frame(8'h00);
        run_frame(0, 0, 1'b0, 1'b0);

        make_frame(0, 1'b1);
        run_frame(0, 0, 1'b0, 1'b0);
        make_frame(65, 1'b1);
        run_frame(0, 0, 1'b0, 1'b0);

        nominal_frame(8'hA5);
        run_frame(3, 3, 1'b0, 1'b0);

        nominal_frame(8'hA5);
        model_frame();
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rx_ready", 32'(rx_ready), 32'd0);
        check("arst_we", 32'(we), 32'd0);
        check("arst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_wAddr", wAddr, 32'd0);
        check("arst_wData", wData, 32'd0);
        check("arst_writes_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        nominal_frame(8'hA5);
        run_frame(0, 1, 1'b0, 1'b0);

        make_frame(3, 1'b1);
        run_frame(0, 1, 1'b1, 1'b0);
        nominal_frame(8'hA5);
        run_frame(0, 0, 1'b0, 1'b1);

        make_frame(DEPTH, 1'b1);
        run_frame(0, 1, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) == 0
                    ? 0 : int'($urandom_range(DEPTH + 1, 255)))
                : int'($urandom_range(1, 6));
            make_frame(n, $urandom_range(0, 3) != 0);
            run_frame(0, 2, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
